// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: shared constants for the memory-mapped countdown timer.
// Word offsets are memaddr[4:2] inside the 32-byte register window.
package mmio_timer_pkg;

   // Width of the PRESCALE register and of the internal prescaler counter
   localparam int PRESCALE_W = 16;

   // Register word offsets (memaddr[4:2])
   localparam logic [2:0] OFS_CTRL     = 3'd0;
   localparam logic [2:0] OFS_LOAD     = 3'd1;
   localparam logic [2:0] OFS_COUNT    = 3'd2;
   localparam logic [2:0] OFS_STATUS   = 3'd3;
   localparam logic [2:0] OFS_PRESCALE = 3'd4;
   localparam logic [2:0] OFS_CYCLES   = 3'd5;

   // CTRL bit positions
   localparam int CTRL_EN = 0;
   localparam int CTRL_AR = 1;
   localparam int CTRL_IE = 2;

   // STATUS bit positions
   localparam int STATUS_EXP = 0;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: divides the clock by (limit+1) while enabled.
// pcnt sits at 0 while disabled; clear forces it back to 0 for a fresh period.
module timer_prescaler
   import mmio_timer_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  clear,
   input  logic [PRESCALE_W-1:0] limit,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] pcnt;

   // A tick fires on the cycle the counter has reached the limit
   assign tick = enable & (pcnt == limit);

   // Count up while enabled and wrap exactly at the limit; clear or disable restart at 0
   always_ff @(posedge clk) begin
      if (reset) begin
         pcnt <= '0;
      end else if (clear || !enable || (pcnt == limit)) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped countdown timer on the CPU data bus.
// Reads are combinational so a load completes in the same cycle; writes land
// on the rising edge when memwrite & sel.
// Optional macro MMIO_TIMER_CYCLES_EN adds the free-running CYCLES counter at 0x14.
module mmio_timer
   import mmio_timer_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
   parameter int          CNT_W     = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] memaddr,
   input  logic [31:0] memwritedata,
   output logic        sel,
   output logic [31:0] memreaddata,
   output logic        irq
);

   logic [2:0]            ofs;
   logic                  wr;
   logic                  wr_ctrl;
   logic                  wr_load;
   logic                  wr_count;
   logic                  wr_status;
   logic                  wr_prescale;
   logic [CNT_W-1:0]      wdata_cnt;

   logic                  en;
   logic                  ar;
   logic                  ie;
   logic [CNT_W-1:0]      load;
   logic [CNT_W-1:0]      count;
   logic                  exp;
   logic [PRESCALE_W-1:0] prescale;

   logic                  tick;
   logic                  tick_eff;
   logic                  pclear;
   logic [CNT_W-1:0]      count_nxt;
   logic                  exp_set;
   logic                  en_off;

   logic                  unused_bits;

   // Byte lane bits are ignored; the data bits feed registers of various widths
   assign unused_bits = ^{memaddr[1:0], memwritedata};

   assign sel         = (memaddr[31:5] == BASE_ADDR[31:5]);
   assign ofs         = memaddr[4:2];
   assign wr          = memwrite & sel;
   assign wr_ctrl     = wr & (ofs == OFS_CTRL);
   assign wr_load     = wr & (ofs == OFS_LOAD);
   assign wr_count    = wr & (ofs == OFS_COUNT);
   assign wr_status   = wr & (ofs == OFS_STATUS);
   assign wr_prescale = wr & (ofs == OFS_PRESCALE);
   assign wdata_cnt   = memwritedata[CNT_W-1:0];

   // Restart the prescale period on LOAD or PRESCALE writes and when EN goes 0->1
   assign pclear = wr_load | wr_prescale | (wr_ctrl & memwritedata[CTRL_EN] & ~en);

   // A CPU write to CTRL, LOAD or COUNT owns the counter this cycle, so the tick is lost
   assign tick_eff = tick & ~(wr_ctrl | wr_load | wr_count);

   assign irq = exp & ie;

   timer_prescaler u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .enable (en),
      .clear  (pclear),
      .limit  (prescale),
      .tick   (tick)
   );

   // Countdown decision for the current tick: decrement, expire, reload or stop
   always_comb begin
      count_nxt = count;
      exp_set   = 1'b0;
      en_off    = 1'b0;
      if (tick_eff) begin
         if (count > CNT_W'(1)) begin
            count_nxt = count - CNT_W'(1);
         end else if (count == CNT_W'(1)) begin
            exp_set = 1'b1;
            if (ar) begin
               count_nxt = load;
            end else begin
               count_nxt = '0;
               en_off    = 1'b1;
            end
         end else begin
            if (ar) begin
               count_nxt = load;
            end else begin
               en_off = 1'b1;
            end
         end
      end
   end

   // CTRL fields; a one-shot expiry drops EN when the CPU is not writing CTRL
   always_ff @(posedge clk) begin
      if (reset) begin
         en <= 1'b0;
         ar <= 1'b0;
         ie <= 1'b0;
      end else if (wr_ctrl) begin
         en <= memwritedata[CTRL_EN];
         ar <= memwritedata[CTRL_AR];
         ie <= memwritedata[CTRL_IE];
      end else if (en_off) begin
         en <= 1'b0;
      end
   end

   // LOAD and COUNT; CPU writes take priority over the countdown
   always_ff @(posedge clk) begin
      if (reset) begin
         load  <= '0;
         count <= '0;
      end else if (wr_load) begin
         load  <= wdata_cnt;
         count <= wdata_cnt;
      end else if (wr_count) begin
         count <= wdata_cnt;
      end else begin
         count <= count_nxt;
      end
   end

   // EXP is write-1-to-clear, but a same-cycle expiry keeps it set
   always_ff @(posedge clk) begin
      if (reset) begin
         exp <= 1'b0;
      end else begin
         exp <= exp_set | (exp & ~(wr_status & memwritedata[STATUS_EXP]));
      end
   end

   // PRESCALE register holds the divider limit
   always_ff @(posedge clk) begin
      if (reset) begin
         prescale <= '0;
      end else if (wr_prescale) begin
         prescale <= memwritedata[PRESCALE_W-1:0];
      end
   end

`ifdef MMIO_TIMER_CYCLES_EN
   logic [31:0] cycles;

   // Free-running cycle counter, loadable by the CPU, wraps naturally
   always_ff @(posedge clk) begin
      if (reset) begin
         cycles <= '0;
      end else if (wr && (ofs == OFS_CYCLES)) begin
         cycles <= memwritedata;
      end else begin
         cycles <= cycles + 32'd1;
      end
   end
`endif

   // Zero-latency read mux; unused bits and unmapped offsets read 0
   always_comb begin
      memreaddata = '0;
      if (sel) begin
         case (ofs)
            OFS_CTRL: begin
               memreaddata[CTRL_EN] = en;
               memreaddata[CTRL_AR] = ar;
               memreaddata[CTRL_IE] = ie;
            end
            OFS_LOAD:     memreaddata[CNT_W-1:0]      = load;
            OFS_COUNT:    memreaddata[CNT_W-1:0]      = count;
            OFS_STATUS:   memreaddata[STATUS_EXP]     = exp;
            OFS_PRESCALE: memreaddata[PRESCALE_W-1:0] = prescale;
`ifdef MMIO_TIMER_CYCLES_EN
            OFS_CYCLES:   memreaddata                 = cycles;
`endif
            default:      memreaddata                 = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: scoreboard bench for mmio_timer.
// Expected read data, irq and sel are queued when a read is driven and
// popped and compared once the combinational output has settled.
module tb_mmio_timer;

   localparam logic [31:0] BASE = 32'hFFFF_FF00;

   logic        clk;
   logic        reset;
   logic        memwrite;
   logic [31:0] memaddr;
   logic [31:0] memwritedata;
   logic        sel;
   logic [31:0] memreaddata;
   logic        irq;

   int total;
   int bad;

   typedef struct {
      string       tag;
      logic [31:0] rd;
      logic        irq;
      logic        sel;
   } sb_entry_t;

   sb_entry_t sb[$];

   mmio_timer dut (
      .clk          (clk),
      .reset        (reset),
      .memwrite     (memwrite),
      .memaddr      (memaddr),
      .memwritedata (memwritedata),
      .sel          (sel),
      .memreaddata  (memreaddata),
      .irq          (irq)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s got=0x%08h want=0x%08h", tag, got, want);
      end
   endtask

   // One bus cycle driven from the negedge; reads queue their expectations
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] data,
                                input logic chk, input string tag, input logic [31:0] exprd,
                                input logic expirq, input logic expsel);
      sb_entry_t e;
      memwrite     = we;
      memaddr      = addr;
      memwritedata = data;
      if (chk) begin
         e.tag = tag;
         e.rd  = exprd;
         e.irq = expirq;
         e.sel = expsel;
         sb.push_back(e);
      end
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput({e.tag, ".rd"},  memreaddata,       e.rd);
         checkOutput({e.tag, ".irq"}, {31'd0, irq},      {31'd0, e.irq});
         checkOutput({e.tag, ".sel"}, {31'd0, sel},      {31'd0, e.sel});
      end
      @(negedge clk);
      memwrite = 1'b0;
   endtask

   task automatic writeReg(input int ofs, input logic [31:0] data);
      applyStimulus(1'b1, BASE + 32'(ofs), data, 1'b0, "", 32'd0, 1'b0, 1'b0);
   endtask

   task automatic readReg(input string tag, input int ofs, input logic [31:0] exprd, input logic expirq);
      applyStimulus(1'b0, BASE + 32'(ofs), 32'd0, 1'b1, tag, exprd, expirq, 1'b1);
   endtask

   task automatic doReset(input int n);
      reset    = 1'b1;
      memwrite = 1'b0;
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      logic [31:0] expv;
      logic [31:0] seq_ar [7];
      total        = 0;
      bad          = 0;
      memwrite     = 1'b0;
      memaddr      = 32'd0;
      memwritedata = 32'd0;
      reset        = 1'b1;

      // Reset and decode: every offset reads 0, off-window address deselects
      doReset(2);
      for (int i = 0; i < 8; i++) begin
         expv = 32'd0;
`ifdef MMIO_TIMER_CYCLES_EN
         if (i == 5) expv = 32'd5;
`endif
         readReg($sformatf("rst_ofs%0d", i * 4), i * 4, expv, 1'b0);
      end
      applyStimulus(1'b0, 32'h1000_0000, 32'd0, 1'b1, "offwindow", 32'd0, 1'b0, 1'b0);

      // PRESCALE keeps only its low 16 bits
      writeReg(16, 32'hFFFF_1234);
      readReg("prescale_mask", 16, 32'h0000_1234, 1'b0);

      // One-shot with interrupt enabled
      writeReg(16, 32'd0);
      writeReg(4, 32'd3);
      writeReg(0, 32'h5);
      readReg("os_cnt3", 8, 32'd3, 1'b0);
      readReg("os_cnt2", 8, 32'd2, 1'b0);
      readReg("os_cnt1", 8, 32'd1, 1'b0);
      readReg("os_cnt0", 8, 32'd0, 1'b1);
      readReg("os_status", 12, 32'd1, 1'b1);
      readReg("os_ctrl", 0, 32'h4, 1'b1);
      readReg("os_hold0", 8, 32'd0, 1'b1);
      writeReg(12, 32'd1);
      writeReg(0, 32'd0);
      readReg("os_cleared", 12, 32'd0, 1'b0);

      // Auto-reload with PRESCALE=2, interrupt disabled
      seq_ar = '{32'd2, 32'd2, 32'd2, 32'd1, 32'd1, 32'd1, 32'd2};
      writeReg(16, 32'd2);
      writeReg(4, 32'd2);
      writeReg(0, 32'h3);
      for (int i = 0; i < 7; i++) begin
         readReg($sformatf("ar_cnt%0d", i), 8, seq_ar[i], 1'b0);
      end
      readReg("ar_status", 12, 32'd1, 1'b0);
      readReg("ar_ctrl", 0, 32'h3, 1'b0);
      writeReg(0, 32'd0);
      writeReg(12, 32'd1);

      // Expiry set collides with a W1C of EXP: set wins
      writeReg(16, 32'd0);
      writeReg(4, 32'd2);
      writeReg(0, 32'h1);
      readReg("col_cnt2", 8, 32'd2, 1'b0);
      writeReg(12, 32'd1);
      readReg("col_exp_kept", 12, 32'd1, 1'b0);
      readReg("col_cnt0", 8, 32'd0, 1'b0);
      readReg("col_en_off", 0, 32'd0, 1'b0);
      writeReg(12, 32'd1);
      readReg("col_exp_clr", 12, 32'd0, 1'b0);

      // COUNT write on a tick cycle: the write wins
      writeReg(4, 32'h20);
      writeReg(0, 32'h1);
      writeReg(8, 32'h10);
      readReg("wt_cnt10", 8, 32'h10, 1'b0);
      readReg("wt_cnt0f", 8, 32'h0F, 1'b0);

      // Reset in the middle of a countdown
      writeReg(8, 32'd5);
      doReset(1);
      readReg("mr_count", 8, 32'd0, 1'b0);
      readReg("mr_ctrl", 0, 32'd0, 1'b0);
      readReg("mr_status", 12, 32'd0, 1'b0);
      readReg("mr_load", 4, 32'd0, 1'b0);

      // CYCLES load and wrap, or ignored when the counter is not built
      writeReg(20, 32'hFFFF_FFFF);
`ifdef MMIO_TIMER_CYCLES_EN
      readReg("cyc_loaded", 20, 32'hFFFF_FFFF, 1'b0);
      readReg("cyc_wrapped", 20, 32'd0, 1'b0);
`else
      readReg("cyc_absent", 20, 32'd0, 1'b0);
      readReg("cyc_absent2", 20, 32'd0, 1'b0);
`endif
      writeReg(24, 32'hABCD_0123);
      readReg("ofs18_zero", 24, 32'd0, 1'b0);
      readReg("ofs1c_zero", 28, 32'd0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
